// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and supervision: drives the PLL reset, qualifies LOCK through a
// synchroniser, retries on lock timeout and releases staged downstream resets.
module pll_lock_supervisor #(
    parameter int unsigned N_OUT        = 4,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned STAGE_GAP    = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             force_reset,
    input  logic             err_clr,
    output logic             pll_rst,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic             timeout_err,
    output logic [CNT_W-1:0] lock_lost_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_PRST = 3'd0,
        S_WAIT = 3'd1,
        S_STAB = 3'd2,
        S_REL  = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    // One shared timer; sized so the release sequence end value also fits.
    localparam int unsigned REL_SPAN = N_OUT * STAGE_GAP;
    localparam int unsigned MAX_AB   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int unsigned MAX_ABC  = (MAX_AB > REL_SPAN) ? MAX_AB : REL_SPAN;
    localparam int unsigned MAX_ALL  = (MAX_ABC > RST_HOLD) ? MAX_ABC : RST_HOLD;
    localparam int unsigned TW       = $clog2(MAX_ALL + 1);

    localparam logic [TW-1:0]    HOLD_LAST = TW'(RST_HOLD - 1);
    localparam logic [TW-1:0]    TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STAB_LAST = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0]    REL_DONE  = TW'((N_OUT - 1) * STAGE_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [N_OUT-1:0]       rst_out_d;
    logic [CNT_W-1:0]       cnt_d;
    logic                   err_d;
    logic                   timeout_hit;
    logic                   lk;

    assign lk    = sync_q[SYNC_STAGES-1];
    assign state = state_q;

    // State, timer, synchroniser and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_PRST;
            timer_q       <= '0;
            sync_q        <= '0;
            pll_rst       <= 1'b1;
            rst_out       <= '1;
            ready         <= 1'b0;
            timeout_err   <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            pll_rst       <= (state_d == S_PRST);
            rst_out       <= rst_out_d;
            ready         <= (state_d == S_RUN);
            timeout_err   <= err_d;
            lock_lost_cnt <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rst_out_d   = rst_out;
        cnt_d       = lock_lost_cnt;
        timeout_hit = 1'b0;

        case (state_q)
            S_PRST: begin
                rst_out_d = '1;
                if (timer_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT: begin
                rst_out_d = '1;
                if (lk) begin
                    // The detecting cycle already counts as the first stable one.
                    state_d = S_STAB;
                    timer_d = TW'(1);
                end else if (timer_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_PRST;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STAB: begin
                rst_out_d = '1;
                if (!lk) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else if (timer_q == STAB_LAST) begin
                    state_d = S_REL;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_REL: begin
                if (!lk) begin
                    state_d   = S_PRST;
                    timer_d   = '0;
                    rst_out_d = '1;
                    cnt_d     = (lock_lost_cnt == CNT_MAX) ? CNT_MAX : lock_lost_cnt + CNT_W'(1);
                end else if (timer_q == REL_DONE) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (timer_q == TW'(i * STAGE_GAP)) rst_out_d[i] = 1'b0;
                    end
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                rst_out_d = '0;
                if (!lk) begin
                    state_d   = S_PRST;
                    timer_d   = '0;
                    rst_out_d = '1;
                    cnt_d     = (lock_lost_cnt == CNT_MAX) ? CNT_MAX : lock_lost_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_PRST;
                timer_d   = '0;
                rst_out_d = '1;
            end
        endcase

        // A bring-up request overrides everything else, including a lock loss.
        if (force_reset) begin
            state_d     = S_PRST;
            timer_d     = '0;
            rst_out_d   = '1;
            cnt_d       = lock_lost_cnt;
            timeout_hit = 1'b0;
        end

        err_d = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : timeout_err);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expectations are queued with a due
// cycle when stimulus is driven and compared on the falling edge of that cycle.
module tb_pll_lock_supervisor;

    localparam int unsigned N_OUT = 3;
    localparam int unsigned CNT_W = 2;

    localparam int SEL_STATE = 0;
    localparam int SEL_PRST  = 1;
    localparam int SEL_ROUT  = 2;
    localparam int SEL_RDY   = 3;
    localparam int SEL_ERR   = 4;
    localparam int SEL_CNT   = 5;

    logic             clk;
    logic             rst;
    logic             pll_locked;
    logic             force_reset;
    logic             err_clr;
    logic             pll_rst;
    logic [N_OUT-1:0] rst_out;
    logic             ready;
    logic             timeout_err;
    logic [CNT_W-1:0] lock_lost_cnt;
    logic [2:0]       state;

    pll_lock_supervisor #(
        .N_OUT(N_OUT), .RST_HOLD(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8),
        .STAGE_GAP(2), .SYNC_STAGES(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .force_reset(force_reset),
        .err_clr(err_clr), .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready),
        .timeout_err(timeout_err), .lock_lost_cnt(lock_lost_cnt), .state(state)
    );

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_STATE: return 8'(state);
            SEL_PRST:  return 8'(pll_rst);
            SEL_ROUT:  return 8'(rst_out);
            SEL_RDY:   return 8'(ready);
            SEL_ERR:   return 8'(timeout_err);
            default:   return 8'(lock_lost_cnt);
        endcase
    endfunction

    // Scoreboard consumer: compare every entry due in this cycle.
    always @(negedge clk) begin
        logic [7:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                obs   = observe(sb[i].sel);
                n_cmp = n_cmp + 1;
                assert (obs === sb[i].exp) else begin
                    n_err = n_err + 1;
                    $error("FAIL %s @cyc %0d: observed %0h expected %0h", sb[i].tag, cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push_exp(input int due, input int sel, input logic [7:0] v, input string tag);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Lock qualified on cycle e-1 (state S_STAB from edge e); full release sequence.
    task automatic push_bringup(input int e);
        push_exp(e - 1,  SEL_STATE, 8'd1, "wait_before_stab");
        push_exp(e,      SEL_STATE, 8'd2, "stab_entry");
        push_exp(e,      SEL_PRST,  8'd0, "pll_rst_low_stab");
        push_exp(e + 6,  SEL_STATE, 8'd2, "stab_last");
        push_exp(e + 6,  SEL_ROUT,  8'd7, "rst_out_held_stab");
        push_exp(e + 7,  SEL_STATE, 8'd3, "rel_entry");
        push_exp(e + 7,  SEL_ROUT,  8'd7, "rst_out_rel_entry");
        push_exp(e + 8,  SEL_ROUT,  8'd6, "rst_out0_release");
        push_exp(e + 9,  SEL_ROUT,  8'd6, "rst_out_gap0");
        push_exp(e + 10, SEL_ROUT,  8'd4, "rst_out1_release");
        push_exp(e + 11, SEL_ROUT,  8'd4, "rst_out_gap1");
        push_exp(e + 12, SEL_ROUT,  8'd0, "rst_out2_release");
        push_exp(e + 12, SEL_RDY,   8'd0, "ready_not_yet");
        push_exp(e + 12, SEL_STATE, 8'd3, "rel_last");
        push_exp(e + 13, SEL_RDY,   8'd1, "ready_rise");
        push_exp(e + 13, SEL_STATE, 8'd4, "run_entry");
        push_exp(e + 13, SEL_ROUT,  8'd0, "rst_out_run");
    endtask

    // Drop pll_locked from RUN; returns the drop cycle with pll_locked still low.
    task automatic lose_lock(input logic [7:0] cnt_exp, output int f);
        f = cyc;
        pll_locked = 1'b0;
        push_exp(f + 2, SEL_RDY,   8'd1, "ready_before_loss");
        push_exp(f + 2, SEL_ROUT,  8'd0, "rst_out_before_loss");
        push_exp(f + 3, SEL_STATE, 8'd0, "loss_state");
        push_exp(f + 3, SEL_ROUT,  8'd7, "loss_rst_out");
        push_exp(f + 3, SEL_RDY,   8'd0, "loss_ready");
        push_exp(f + 3, SEL_PRST,  8'd1, "loss_pll_rst");
        push_exp(f + 3, SEL_CNT,   cnt_exp, "loss_cnt");
        step_to(f + 4);
    endtask

    initial begin
        int f;
        int e;
        int e2;
        int w;
        int c1;

        rst         = 1'b1;
        pll_locked  = 1'b0;
        force_reset = 1'b0;
        err_clr     = 1'b0;

        // Reset values.
        step_to(2);
        push_exp(2, SEL_STATE, 8'd0, "rst_state");
        push_exp(2, SEL_PRST,  8'd1, "rst_pll_rst");
        push_exp(2, SEL_ROUT,  8'd7, "rst_rst_out");
        push_exp(2, SEL_RDY,   8'd0, "rst_ready");
        push_exp(2, SEL_ERR,   8'd0, "rst_timeout_err");
        push_exp(2, SEL_CNT,   8'd0, "rst_cnt");

        // Clean bring-up.
        rst = 1'b0;
        push_exp(5, SEL_PRST,  8'd1, "hold_last");
        push_exp(5, SEL_STATE, 8'd0, "hold_state");
        push_exp(6, SEL_PRST,  8'd0, "pll_rst_fall");
        push_exp(6, SEL_STATE, 8'd1, "wait_entry");
        step_to(12);
        pll_locked = 1'b1;
        push_bringup(15);
        push_exp(30, SEL_CNT, 8'd0, "cnt_after_bringup");
        step_to(30);

        // Lock loss #1, then force_reset in S_REL after rst_out[0] released.
        lose_lock(8'd1, f);
        pll_locked = 1'b1;
        e = f + 8;
        push_exp(e,     SEL_STATE, 8'd2, "relock_stab");
        push_exp(e + 7, SEL_STATE, 8'd3, "relock_rel");
        push_exp(e + 8, SEL_ROUT,  8'd6, "relock_rst_out0");
        step_to(e + 9);
        force_reset = 1'b1;
        push_exp(e + 9, SEL_ROUT, 8'd6, "pre_force_rst_out");
        step_to(e + 10);
        force_reset = 1'b0;
        push_exp(e + 10, SEL_STATE, 8'd0, "force_state");
        push_exp(e + 10, SEL_ROUT,  8'd7, "force_rst_out");
        push_exp(e + 10, SEL_PRST,  8'd1, "force_pll_rst");
        push_exp(e + 10, SEL_RDY,   8'd0, "force_ready");
        push_exp(e + 10, SEL_CNT,   8'd1, "force_cnt_kept");
        push_exp(e + 13, SEL_PRST,  8'd1, "force_hold_last");
        push_exp(e + 14, SEL_PRST,  8'd0, "force_hold_end");
        push_exp(e + 14, SEL_STATE, 8'd1, "force_wait");

        // One-cycle glitch on pll_locked while in S_STAB.
        e2 = e + 15;
        push_exp(e2,     SEL_STATE, 8'd2, "glitch_stab_entry");
        push_exp(e2 + 3, SEL_STATE, 8'd2, "glitch_still_stab");
        push_exp(e2 + 4, SEL_STATE, 8'd1, "glitch_back_wait");
        push_exp(e2 + 4, SEL_ROUT,  8'd7, "glitch_rst_out");
        push_exp(e2 + 4, SEL_CNT,   8'd1, "glitch_cnt_kept");
        push_bringup(e2 + 5);
        step_to(e2 + 1);
        pll_locked = 1'b0;
        step_to(e2 + 2);
        pll_locked = 1'b1;
        step_to(e2 + 5 + 15);

        // Lock losses #2..#5: count saturates at 3.
        for (int k = 2; k <= 5; k++) begin
            lose_lock((k >= 3) ? 8'd3 : 8'(k), f);
            pll_locked = 1'b1;
            push_bringup(f + 8);
            step_to(f + 23);
        end

        // Timeout retry with err_clr, including set-wins on a coincident clear.
        lose_lock(8'd3, f);
        w = f + 7;
        push_exp(w,      SEL_STATE, 8'd1, "to_wait_entry");
        push_exp(w + 31, SEL_STATE, 8'd1, "to_wait_last");
        push_exp(w + 31, SEL_ERR,   8'd0, "to_err_before");
        push_exp(w + 32, SEL_STATE, 8'd0, "to_retry_state");
        push_exp(w + 32, SEL_ERR,   8'd1, "to_err_set");
        push_exp(w + 32, SEL_PRST,  8'd1, "to_pll_rst");
        push_exp(w + 35, SEL_PRST,  8'd1, "to_hold_last");
        push_exp(w + 36, SEL_PRST,  8'd0, "to_hold_end");
        push_exp(w + 36, SEL_STATE, 8'd1, "to_wait_again");
        step_to(w + 40);
        err_clr = 1'b1;
        push_exp(w + 40, SEL_ERR, 8'd1, "err_before_clr");
        step_to(w + 41);
        err_clr = 1'b0;
        push_exp(w + 41, SEL_ERR,   8'd0, "err_cleared");
        push_exp(w + 67, SEL_ERR,   8'd0, "err_stays_clear");
        push_exp(w + 67, SEL_STATE, 8'd1, "to2_wait_last");
        step_to(w + 67);
        err_clr = 1'b1;
        step_to(w + 68);
        err_clr = 1'b0;
        push_exp(w + 68, SEL_ERR,   8'd1, "err_set_wins");
        push_exp(w + 68, SEL_STATE, 8'd0, "to2_retry_state");
        push_exp(w + 69, SEL_ERR,   8'd1, "err_sticky");
        push_exp(w + 68, SEL_CNT,   8'd3, "to_cnt_kept");

        // Relock, then async reset mid-S_REL.
        step_to(w + 69);
        pll_locked = 1'b1;
        e = w + 73;
        push_exp(e - 1, SEL_STATE, 8'd1, "pre_arst_wait");
        push_exp(e,     SEL_STATE, 8'd2, "pre_arst_stab");
        push_exp(e + 7, SEL_STATE, 8'd3, "pre_arst_rel");
        push_exp(e + 8, SEL_ROUT,  8'd6, "pre_arst_rst_out0");
        push_exp(e + 8, SEL_STATE, 8'd3, "pre_arst_rel2");
        step_to(e + 9);
        #1;
        rst = 1'b1;
        push_exp(e + 9, SEL_STATE, 8'd0, "arst_state");
        push_exp(e + 9, SEL_PRST,  8'd1, "arst_pll_rst");
        push_exp(e + 9, SEL_ROUT,  8'd7, "arst_rst_out");
        push_exp(e + 9, SEL_RDY,   8'd0, "arst_ready");
        push_exp(e + 9, SEL_ERR,   8'd0, "arst_timeout_err");
        push_exp(e + 9, SEL_CNT,   8'd0, "arst_cnt");
        step_to(e + 11);
        rst = 1'b0;
        c1 = cyc;
        push_exp(c1 + 3, SEL_PRST,  8'd1, "post_arst_hold_last");
        push_exp(c1 + 3, SEL_STATE, 8'd0, "post_arst_prst");
        push_exp(c1 + 4, SEL_PRST,  8'd0, "post_arst_hold_end");
        push_bringup(c1 + 5);
        push_exp(c1 + 19, SEL_CNT, 8'd0, "post_arst_cnt");
        push_exp(c1 + 19, SEL_ERR, 8'd0, "post_arst_err");
        step_to(c1 + 21);

        n_cmp = n_cmp + 1;
        assert (sb.size() === 0) else begin
            n_err = n_err + 1;
            $error("FAIL sb_drain: %0d expectations never compared, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
